// File: rtl/zap_memory_stage.sv
// ---------------------------------------------------------------------------
// zap_memory_stage
//
// Pipeline stage between the ALU stage and writeback. Registers the ALU
// result (write port 0) and, for loads, waits for the data bus to
// acknowledge, then aligns and extends the read data onto write port 1.
// A bus error on the acknowledge becomes a one-cycle data abort.
//
// Ports:
//   i_clk, i_reset_n         clock, asynchronous active-low reset
//   i_clear_from_writeback   synchronous flush, highest priority
//   i_alu_*                  instruction fields from the ALU stage
//   i_dbus_ack/err/rdata     data bus response
//   o_stall                  combinational stall to all upstream stages
//   o_valid                  instruction valid to writeback
//   o_wr_index/o_wr_data     write port 0 (ALU result)
//   o_wr_index_1/o_wr_data_1 write port 1 (load data), enabled by o_mem_load_ff
//   o_flags, o_pc_buf_ff     flags and PC+8 to writeback
//   o_irq .. o_data_abt      exception indications to writeback
// ---------------------------------------------------------------------------
module zap_memory_stage #(
    parameter int unsigned                 PHY_REGS  = 46,
    parameter int unsigned                 FLAG_WDT  = 32,
    parameter logic [$clog2(PHY_REGS)-1:0] RAZ_INDEX = 6'd36
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic                        i_clear_from_writeback,
    input  logic                        i_alu_valid,
    input  logic [31:0]                 i_alu_result,
    input  logic [$clog2(PHY_REGS)-1:0] i_alu_wr_index,
    input  logic                        i_alu_mem_load,
    input  logic [1:0]                  i_alu_mem_size,
    input  logic                        i_alu_mem_signed,
    input  logic [1:0]                  i_alu_mem_addr_lo,
    input  logic [$clog2(PHY_REGS)-1:0] i_alu_mem_dst_index,
    input  logic [FLAG_WDT-1:0]         i_alu_flags,
    input  logic [31:0]                 i_alu_pc_plus_8,
    input  logic                        i_alu_irq,
    input  logic                        i_alu_fiq,
    input  logic                        i_alu_swi,
    input  logic                        i_alu_und,
    input  logic                        i_alu_instr_abt,
    input  logic                        i_dbus_ack,
    input  logic                        i_dbus_err,
    input  logic [31:0]                 i_dbus_rdata,
    output logic                        o_stall,
    output logic                        o_valid,
    output logic [$clog2(PHY_REGS)-1:0] o_wr_index,
    output logic [$clog2(PHY_REGS)-1:0] o_wr_index_1,
    output logic [31:0]                 o_wr_data,
    output logic [31:0]                 o_wr_data_1,
    output logic                        o_mem_load_ff,
    output logic [FLAG_WDT-1:0]         o_flags,
    output logic [31:0]                 o_pc_buf_ff,
    output logic                        o_irq,
    output logic                        o_fiq,
    output logic                        o_swi,
    output logic                        o_und,
    output logic                        o_instr_abt,
    output logic                        o_data_abt
);

    localparam int unsigned IW = $clog2(PHY_REGS);

    typedef enum logic {StIdle, StWait} state_e;

    state_e          state;
    logic [1:0]      ld_size;
    logic            ld_signed;
    logic [1:0]      ld_addr_lo;
    logic [IW-1:0]   ld_dst_index;

    logic            exc_any;
    logic            start_load;
    logic [31:0]     rot_word;
    logic [15:0]     sel_half;
    logic [7:0]      sel_byte;
    logic [31:0]     aligned;

    assign o_stall = (state == StWait) & ~i_dbus_ack;

    assign exc_any    = i_alu_irq | i_alu_fiq | i_alu_swi | i_alu_und | i_alu_instr_abt;
    // An instruction that already carries an exception never issues its load.
    assign start_load = i_alu_valid & i_alu_mem_load & ~exc_any;

    // Load data alignment uses the fields captured when the load was issued.
    always_comb begin
        rot_word = i_dbus_rdata;
        sel_byte = i_dbus_rdata[7:0];
        unique case (ld_addr_lo)
            2'd0: begin
                rot_word = i_dbus_rdata;
                sel_byte = i_dbus_rdata[7:0];
            end
            2'd1: begin
                rot_word = {i_dbus_rdata[7:0], i_dbus_rdata[31:8]};
                sel_byte = i_dbus_rdata[15:8];
            end
            2'd2: begin
                rot_word = {i_dbus_rdata[15:0], i_dbus_rdata[31:16]};
                sel_byte = i_dbus_rdata[23:16];
            end
            2'd3: begin
                rot_word = {i_dbus_rdata[23:0], i_dbus_rdata[31:24]};
                sel_byte = i_dbus_rdata[31:24];
            end
            default: ;
        endcase
        sel_half = ld_addr_lo[1] ? i_dbus_rdata[31:16] : i_dbus_rdata[15:0];

        unique case (ld_size)
            2'd1:    aligned = {{16{ld_signed & sel_half[15]}}, sel_half};
            2'd2:    aligned = {{24{ld_signed & sel_byte[7]}}, sel_byte};
            default: aligned = rot_word; // size 0 and the reserved size 3
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state         <= StIdle;
            ld_size       <= 2'd0;
            ld_signed     <= 1'b0;
            ld_addr_lo    <= 2'd0;
            ld_dst_index  <= RAZ_INDEX;
            o_valid       <= 1'b0;
            o_wr_index    <= RAZ_INDEX;
            o_wr_index_1  <= RAZ_INDEX;
            o_wr_data     <= 32'd0;
            o_wr_data_1   <= 32'd0;
            o_mem_load_ff <= 1'b0;
            o_flags       <= '0;
            o_pc_buf_ff   <= 32'd0;
            o_irq         <= 1'b0;
            o_fiq         <= 1'b0;
            o_swi         <= 1'b0;
            o_und         <= 1'b0;
            o_instr_abt   <= 1'b0;
            o_data_abt    <= 1'b0;
        end else if (i_clear_from_writeback) begin
            // Flush wins over both a pending ack and a new capture.
            state         <= StIdle;
            o_valid       <= 1'b0;
            o_mem_load_ff <= 1'b0;
            o_wr_index_1  <= RAZ_INDEX;
            o_irq         <= 1'b0;
            o_fiq         <= 1'b0;
            o_swi         <= 1'b0;
            o_und         <= 1'b0;
            o_instr_abt   <= 1'b0;
            o_data_abt    <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    ld_size       <= i_alu_mem_size;
                    ld_signed     <= i_alu_mem_signed;
                    ld_addr_lo    <= i_alu_mem_addr_lo;
                    ld_dst_index  <= i_alu_mem_dst_index;
                    o_wr_data     <= i_alu_result;
                    o_wr_index    <= i_alu_wr_index;
                    o_flags       <= i_alu_flags;
                    o_pc_buf_ff   <= i_alu_pc_plus_8;
                    o_irq         <= i_alu_irq;
                    o_fiq         <= i_alu_fiq;
                    o_swi         <= i_alu_swi;
                    o_und         <= i_alu_und;
                    o_instr_abt   <= i_alu_instr_abt;
                    o_data_abt    <= 1'b0;
                    o_mem_load_ff <= 1'b0;
                    o_wr_index_1  <= RAZ_INDEX;
                    // A load reports valid only once its data has returned.
                    o_valid       <= i_alu_valid & ~start_load;
                    if (start_load) begin
                        state <= StWait;
                    end
                end
                StWait: begin
                    if (i_dbus_ack) begin
                        state <= StIdle;
                        if (i_dbus_err) begin
                            o_data_abt    <= 1'b1;
                            o_valid       <= 1'b0;
                            o_mem_load_ff <= 1'b0;
                            o_wr_index_1  <= RAZ_INDEX;
                        end else begin
                            o_valid       <= 1'b1;
                            o_mem_load_ff <= 1'b1;
                            o_wr_index_1  <= ld_dst_index;
                            o_wr_data_1   <= aligned;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
